// File: rtl/reflet_mem_bridge.sv
// reflet_mem_bridge: CPU level bus to request/grant/response memory bus with a one-entry read buffer
module reflet_mem_bridge #(
  parameter int wordsize = 16,
  parameter int timeout  = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [wordsize-1:0] cpu_addr,
  input  logic [wordsize-1:0] cpu_data_out,
  input  logic                cpu_write_en,
  output logic [wordsize-1:0] cpu_data_in,
  output logic                mem_ready,
  output logic                bus_req,
  output logic [wordsize-1:0] bus_addr,
  output logic [wordsize-1:0] bus_wdata,
  output logic                bus_we,
  input  logic                bus_gnt,
  input  logic                bus_rvalid,
  input  logic [wordsize-1:0] bus_rdata,
  output logic                bus_error
);
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  localparam int CW = timeout > 1 ? $clog2(timeout) : 1;
  state_t              r_state;
  logic [wordsize-1:0] r_buf_addr, r_buf_data;
  logic                r_buf_valid, r_wr_done;
  logic [CW-1:0]       r_cnt;
  logic                w_match, w_hit, w_timeout;
  assign w_match     = cpu_addr == r_buf_addr;
  assign w_hit       = r_buf_valid && w_match && !cpu_write_en;
  assign mem_ready   = r_state == IDLE && (w_hit || (cpu_write_en && r_wr_done && w_match));
  assign w_timeout   = timeout != 0 && r_cnt == CW'(timeout - 1);
  assign cpu_data_in = r_buf_data;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_buf_addr  <= '0;
      r_buf_data  <= '0;
      r_buf_valid <= 1'b0;
      r_wr_done   <= 1'b0;
      r_cnt       <= '0;
      bus_req     <= 1'b0;
      bus_addr    <= '0;
      bus_wdata   <= '0;
      bus_we      <= 1'b0;
      bus_error   <= 1'b0;
    end else begin
      bus_error <= 1'b0;
      if (r_state == IDLE) begin
        // a completed write only counts while the same write is still being held
        if (!cpu_write_en || !w_match) r_wr_done <= 1'b0;
        if (!mem_ready) begin
          bus_addr  <= cpu_addr;
          bus_wdata <= cpu_data_out;
          bus_we    <= cpu_write_en;
          bus_req   <= 1'b1;
          r_cnt     <= '0;
          r_state   <= REQ;
        end
      end else begin
        r_cnt <= r_cnt + 1'b1;
        if (r_state == REQ && bus_gnt) begin
          bus_req <= 1'b0;
          r_state <= bus_we ? IDLE : RESP;
          if (bus_we) begin
            r_buf_addr  <= bus_addr;
            r_buf_data  <= bus_wdata;
            r_buf_valid <= 1'b1;
            r_wr_done   <= 1'b1;
          end
        end else if (r_state == RESP && bus_rvalid) begin
          r_buf_addr  <= bus_addr;
          r_buf_data  <= bus_rdata;
          r_buf_valid <= 1'b1;
          r_wr_done   <= 1'b0;
          r_state     <= IDLE;
        end else if (w_timeout) begin
          bus_req     <= 1'b0;
          bus_error   <= 1'b1;
          r_buf_addr  <= bus_addr;
          r_buf_data  <= '0;
          r_buf_valid <= 1'b1;
          r_wr_done   <= cpu_write_en;
          r_state     <= IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_reflet_mem_bridge.sv
// tb_reflet_mem_bridge: directed vectors against hand-computed bridge responses
module tb_reflet_mem_bridge;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_addr, cpu_data_out, cpu_data_in, bus_addr, bus_wdata, bus_rdata;
  logic        cpu_write_en, mem_ready, bus_req, bus_we, bus_gnt, bus_rvalid, bus_error;
  int          n_vec = 0, n_err = 0, n_txn = 0, t0;
  logic        prev_req = 1'b0;

  reflet_mem_bridge #(.wordsize(16), .timeout(8)) dut (
    .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_data_out(cpu_data_out),
    .cpu_write_en(cpu_write_en), .cpu_data_in(cpu_data_in), .mem_ready(mem_ready),
    .bus_req(bus_req), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we),
    .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata), .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus_req && !prev_req) n_txn++;
    prev_req = bus_req;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; cpu_addr = '0; cpu_data_out = '0; cpu_write_en = 1'b0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    #12;
    chk("rst_ready", mem_ready, 0);
    chk("rst_req", bus_req, 0);
    chk("rst_data", cpu_data_in, 0);
    chk("rst_err", bus_error, 0);
    chk("rst_addr", bus_addr, 0);
    tick(); reset = 1'b1;

    // read miss then hit
    t0 = n_txn; cpu_addr = 16'h0010;
    tick();
    chk("rd_req", bus_req, 1); chk("rd_addr", bus_addr, 16'h0010); chk("rd_we", bus_we, 0);
    chk("rd_busy1", mem_ready, 0);
    bus_gnt = 1'b1;
    tick();
    chk("rd_req_drop", bus_req, 0); chk("rd_busy2", mem_ready, 0);
    bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 16'hBEEF;
    tick();
    bus_rvalid = 1'b0; bus_rdata = 16'h0000;
    chk("rd_ready3", mem_ready, 1); chk("rd_data", cpu_data_in, 16'hBEEF);
    tick(3);
    chk("rd_hit", mem_ready, 1); chk("rd_txn", n_txn - t0, 1);

    // write with two wait cycles, then read-back from the buffer
    t0 = n_txn; cpu_addr = 16'h0020; cpu_data_out = 16'h1234; cpu_write_en = 1'b1;
    tick();
    chk("wr_req", bus_req, 1); chk("wr_we", bus_we, 1); chk("wr_wdata", bus_wdata, 16'h1234);
    tick();
    chk("wr_wait1", bus_req, 1); chk("wr_busy", mem_ready, 0);
    tick();
    chk("wr_wait2", bus_req, 1);
    bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0;
    chk("wr_done_req", bus_req, 0); chk("wr_ready", mem_ready, 1);
    cpu_write_en = 1'b0; #1;
    chk("rb_ready", mem_ready, 1); chk("rb_data", cpu_data_in, 16'h1234);
    tick(2);
    chk("rb_hold", mem_ready, 1); chk("wr_txn", n_txn - t0, 1);

    // address change while the read response is outstanding
    cpu_addr = 16'h0030;
    tick();
    chk("chg_addr1", bus_addr, 16'h0030);
    bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0; cpu_addr = 16'h0040;
    tick();
    chk("chg_resp_busy", mem_ready, 0);
    bus_rvalid = 1'b1; bus_rdata = 16'h3333;
    tick();
    bus_rvalid = 1'b0;
    chk("chg_stale", mem_ready, 0); chk("chg_old_data", cpu_data_in, 16'h3333);
    tick();
    chk("chg_req2", bus_req, 1); chk("chg_addr2", bus_addr, 16'h0040);
    bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 16'h4444;
    tick();
    bus_rvalid = 1'b0;
    chk("chg_ready", mem_ready, 1); chk("chg_data", cpu_data_in, 16'h4444);

    // timeout with no grant
    cpu_addr = 16'h0050;
    tick();
    chk("to_req", bus_req, 1);
    tick(7);
    chk("to_req7", bus_req, 1); chk("to_err7", bus_error, 0);
    tick();
    chk("to_req8", bus_req, 0); chk("to_err8", bus_error, 1);
    chk("to_ready", mem_ready, 1); chk("to_data", cpu_data_in, 16'h0000);
    tick();
    chk("to_err_pulse", bus_error, 0); chk("to_hit", mem_ready, 1);

    // async reset while in REQ; the previously buffered 0x0050 must miss afterwards
    cpu_addr = 16'h0060;
    tick();
    chk("ar_req", bus_req, 1);
    #2 reset = 1'b0; #1;
    chk("ar_req_drop", bus_req, 0); chk("ar_ready", mem_ready, 0);
    reset = 1'b1; cpu_addr = 16'h0050; #1;
    chk("ar_miss_ready", mem_ready, 0);
    tick();
    chk("ar_miss_req", bus_req, 1); chk("ar_miss_addr", bus_addr, 16'h0050);
    bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 16'h5555;
    tick();
    bus_rvalid = 1'b0;
    chk("ar_ready2", mem_ready, 1); chk("ar_data", cpu_data_in, 16'h5555);

    // held write issues once; drop and re-raise issues again
    t0 = n_txn; bus_gnt = 1'b1;
    cpu_addr = 16'h0070; cpu_data_out = 16'hAAAA; cpu_write_en = 1'b1;
    tick(10);
    chk("hw_txn1", n_txn - t0, 1); chk("hw_ready", mem_ready, 1); chk("hw_data", cpu_data_in, 16'hAAAA);
    cpu_write_en = 1'b0;
    tick(2);
    chk("hw_txn_drop", n_txn - t0, 1);
    cpu_write_en = 1'b1; cpu_data_out = 16'hBBBB;
    tick(3);
    chk("hw_txn2", n_txn - t0, 2); chk("hw_ready2", mem_ready, 1); chk("hw_data2", cpu_data_in, 16'hBBBB);
    bus_gnt = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/reflet_mem_bridge.md
Name: reflet_mem_bridge

Overview:
- Sits between the CPU address/memory unit and the system memory bus.
- Converts the CPU's level-driven bus into a request/grant/response handshake. The CPU bus is addr, data_out, write_en, and it consumes data_in and mem_ready.
- Produces mem_ready so the address unit stalls on slow memory.
- Keeps a one-entry read buffer so repeated reads of an unchanged address complete without a bus transaction.

Parameters:
- wordsize, 16, width of address and data on both sides.
- timeout, 64, cycles allowed between bus_req and the completing grant/response before the access is aborted; 0 disables the timeout.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- cpu_addr  input  wordsize  address from CPU.
- cpu_data_out  input  wordsize  write data from CPU.
- cpu_write_en  input  1  CPU write request (level).
- cpu_data_in  output  wordsize  read data to CPU.
- mem_ready  output  1  high when cpu_data_in is valid for cpu_addr, or the current write has completed.
- bus_req  output  1  transaction request.
- bus_addr  output  wordsize  latched transaction address.
- bus_wdata  output  wordsize  latched write data.
- bus_we  output  1  latched write flag.
- bus_gnt  input  1  memory accepts request this cycle.
- bus_rvalid  input  1  read data valid this cycle.
- bus_rdata  input  wordsize  read data.
- bus_error  output  1  one-cycle pulse when an access times out.

Behaviour:

Reset (async, reset==0):
- state=IDLE; buf_valid=0; wr_done=0; bus_req=0; bus_we=0.
- bus_addr=0; bus_wdata=0; cpu_data_in=0; mem_ready=0; bus_error=0; timeout counter=0.

States: IDLE, REQ, RESP.

IDLE:
- hit = buf_valid && cpu_addr==buf_addr && !cpu_write_en.
- mem_ready = hit || (cpu_write_en && wr_done && cpu_addr==buf_addr), combinational.
- Otherwise start a transaction: latch bus_addr=cpu_addr, bus_wdata=cpu_data_out, bus_we=cpu_write_en; bus_req=1 next cycle; go to REQ.

REQ:
- bus_req held high with stable bus_addr/bus_wdata/bus_we until bus_gnt sampled high.
- On gnt with bus_we=1:
  - Write complete; bus_req=0.
  - buf_addr=bus_addr, buf_data=bus_wdata, buf_valid=1, wr_done=1.
  - Return to IDLE.
- On gnt with bus_we=0: bus_req=0; go to RESP. bus_rvalid in the same cycle as gnt is not accepted; it is only sampled in RESP.

RESP:
- Wait for bus_rvalid.
- On rvalid: buf_addr=bus_addr, buf_data=bus_rdata, buf_valid=1, wr_done=0; go to IDLE.

Data and mem_ready:
- cpu_data_in = buf_data (registered).
- mem_ready is 0 in REQ and RESP.
- Read latency on a miss with zero-wait memory (gnt in first REQ cycle, rvalid the cycle after) is 3 cycles from address change to mem_ready=1.

Write-completion flag:
- wr_done is cleared whenever cpu_write_en falls or cpu_addr changes while in IDLE.
- As a result, a held write is performed exactly once, and a new write to the same address is re-issued only after write_en drops and rises again.

Timeout:
- The counter increments every cycle in REQ/RESP and resets on entry to REQ.
- If timeout!=0 and the counter reaches timeout-1 without completion:
  - bus_req=0; bus_error pulses 1 cycle.
  - buf_addr=bus_addr, buf_data=0, buf_valid=1, wr_done=cpu_write_en.
  - Return to IDLE. The CPU unstalls with 0 read data.

CPU changes mid-transaction:
- Changes to cpu_addr/cpu_write_en during REQ/RESP are ignored.
- The transaction in flight completes, then IDLE re-evaluates against the buffer. A stale result is not reported ready, because mem_ready requires an address match.

Buffer coherence:
- A write to buf_addr updates buf_data with the written value.
- A write to any other address replaces the buffer entry.

Reset mid-transaction:
- Aborts immediately; bus_req drops asynchronously. No response is consumed afterwards.

Test Plan:
- Read miss, then hit: zero-wait memory, cpu_addr=0x0010, rdata=0xBEEF. Required: bus_req for 1 cycle, mem_ready=1 on the 3rd cycle with data 0xBEEF. Address held: no further bus_req.
- Write then read-back: write 0x1234 to 0x0020, gnt after 2 wait cycles. Required: exactly one bus_req transaction with bus_we=1, bus_wdata=0x1234, mem_ready=1 after gnt. Then a read of 0x0020 returns 0x1234 with no bus_req.
- Address change mid-read: switch cpu_addr 0x0030→0x0040 during RESP. Required: the 0x0030 access completes, mem_ready stays 0, then a new transaction with bus_addr=0x0040 is issued.
- Timeout: timeout=8, bus_gnt never asserted. Required: bus_req low and bus_error pulse exactly 8 cycles after bus_req rose; mem_ready=1 with cpu_data_in=0x0000.
- Async reset during REQ: assert reset mid-cycle. Required: bus_req=0 and mem_ready=0 before the next clock edge. After release, the first access is treated as a miss.
- Repeated write hold: cpu_write_en held 10 cycles at the same address. Required: one bus transaction only. Dropping and re-raising write_en triggers a second transaction.
